emern_raster_pipe: RTL and testbench
====================================

# emern_raster_pipe

Parametrised, pipelined triangle rasterizer for the emern VGA GPU. It replaces the fixed two-polygon pixel core. For every pixel coordinate issued by VGA timing, it evaluates NUM_POLY triangles, resolves depth, and emits one colour at a fixed latency. Polygon configuration is double-buffered: the SPI frontend may write it at any time, and the new set takes effect only at a frame boundary.

## Interface
- NUM_POLY, 2, number of triangles evaluated per pixel (1..8)
- COORD_W, 10, unsigned vertex and pixel coordinate width
- COLOR_W, 6, colour width (r1r0g1g0b1b0 at 6)
- DEPTH_W, 3, depth width; smaller value is nearer
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pix_valid_in  in  1  pixel_x and pixel_y valid this cycle
- pixel_x / pixel_y  in  COORD_W each  pixel coordinate
- frame_start  in  1  single-cycle pulse at the start of vertical blanking
- cfg_wr  in  1  capture all cfg_* inputs into the shadow set
- cfg_poly_en  in  NUM_POLY  per-polygon enable
- cfg_bg_color  in  COLOR_W  background colour
- cfg_color  in  NUM_POLY*COLOR_W  packed colours; polygon 0 in the LSBs
- cfg_vx / cfg_vy  in  NUM_POLY*3*COORD_W each  packed vertices v0, v1, v2 per polygon, LSB first
- cfg_depth  in  NUM_POLY*DEPTH_W  packed depths
- pix_valid_out  out  1  output pixel valid
- pixel_color  out  COLOR_W  resolved colour
- hit_poly  out  NUM_POLY  one-hot winning polygon; 0 means background
- cfg_pending  out  1  shadow set written but not yet active

## Operation
- Edge function for an edge a→b at point p: E = (px−ax)(by−ay) − (py−ay)(bx−ax), signed, width 2·COORD_W+3. No truncation is allowed.
- Edges are v0→v1, v1→v2 and v2→v0.
- A pixel is inside a polygon when all three E ≥ 0 or all three E ≤ 0, excluding the case where all three are 0. Both windings are accepted. A degenerate triangle is never hit. Boundary pixels count as inside.
- Depth resolve:
  - Among enabled, inside polygons, the minimum depth wins.
  - On a depth tie, the lowest index wins.
  - If no polygon wins, the output is cfg_bg_color and hit_poly is 0.
- Double buffering:
  - cfg_wr loads the shadow set and sets cfg_pending.
  - frame_start with cfg_pending set copies shadow to active and clears cfg_pending.
  - frame_start without cfg_pending leaves active unchanged.
  - cfg_wr and frame_start in the same cycle: active takes the pre-write shadow, the shadow takes the new write, and cfg_pending stays 1.
- In-flight pixels keep the configuration they entered with. Stage 1 registers per-polygon enable, colour and depth alongside the edge data.

## Timing
- Fixed latency of 4 cycles, no stall, one pixel per cycle:
  - S1: register coordinate differences and active-config snapshot.
  - S2: products.
  - S3: edge signs and per-polygon inside flags.
  - S4: depth resolve and output register.
- pix_valid_out is pix_valid_in delayed by 4 cycles.
- pixel_color and hit_poly hold their last value while pix_valid_out = 0.
- A pixel entering S1 in the cycle frame_start is sampled sees the new active set.
- Reset values:
  - All pipeline valids 0; pixel_color 0; hit_poly 0; cfg_pending 0.
  - Shadow and active sets all 0. All polygons are disabled, so the output is background 0.
- Reset asserted mid-stream clears pipeline valids asynchronously. No stale pixel appears after reset release.

## Configuration
- EMERN_RASTER_STATS_EN
  - Defined: adds output hit_count [19:0]. An internal counter increments for each valid output pixel with hit_poly ≠ 0 and saturates at 0xFFFFF. On frame_start, hit_count latches the counter and the counter clears. If a counted pixel coincides with frame_start, it is counted into the new frame. Reset value is 0.
  - Undefined: no port and no counter logic.

## Structure
- Package emern_raster_pkg holds:
  - LATENCY = 4.
  - Default widths.
  - Edge-width function (2·COORD_W+3).
  - Packed-field index helpers for vertex, colour and depth slices.
- Sub-module emern_edge_eval: one instance per polygon. It takes the registered differences, computes the three edge products and signs across S2–S3, and outputs an inside flag.
- Depth resolve and double buffering stay in the top of the block.

## Test plan
- Triangle v0(100,100), v1(200,100), v2(100,200), colour 0x30, polygon 0 enabled, bg 0x03, frame_start applied. Expected per pixel:
  - (120,120): colour 0x30, hit_poly 01, 4 cycles after input.
  - (300,300): colour 0x03, hit_poly 00.
  - (150,150) on the hypotenuse: colour 0x30.
- Polygon 0 (depth 5, colour 0x30) and polygon 1 (depth 2, colour 0x0C) overlap at (120,120): output 0x0C, hit_poly 10. With both depths set to 3: output 0x30, hit_poly 01.
- Degenerate triangle (0,0), (50,50), (100,100): points (25,25) and (25,30) both output bg.
- cfg_wr mid-frame with a new colour: output keeps the old colour and cfg_pending = 1. After frame_start, the next pixel uses the new colour and cfg_pending = 0. Simultaneous cfg_wr + frame_start: cfg_pending remains 1.
- Continuous pixel stream with rst pulsed for 1 cycle: pix_valid_out = 0 immediately. Outputs are background 0 until the first new pixel emerges 4 cycles after valid input.
- Stats build: 10 hit pixels and 5 background pixels, then frame_start: hit_count = 10. Counter preloaded near max: hit_count saturates at 0xFFFFF.

Source files
------------

// File: rtl/emern_raster_pkg.sv
// emern_raster_pkg
// Shared constants and helpers for the emern triangle rasterizer.
//   LATENCY            : input-to-output pixel latency in clock cycles
//   *_DEF              : default widths for the rasterizer parameters
//   edge_w()           : width of one edge-function value (2*COORD_W+3)
//   vtx_lsb()          : LSB of a vertex coordinate in the packed cfg_vx/cfg_vy buses
//   color_lsb()        : LSB of a polygon colour in the packed colour bus
//   depth_lsb()        : LSB of a polygon depth in the packed depth bus
package emern_raster_pkg;

    localparam int LATENCY      = 4;
    localparam int NUM_POLY_DEF = 2;
    localparam int COORD_W_DEF  = 10;
    localparam int COLOR_W_DEF  = 6;
    localparam int DEPTH_W_DEF  = 3;

    function automatic int edge_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    function automatic int vtx_lsb(input int poly, input int vtx, input int coord_w);
        return (poly * 3 + vtx) * coord_w;
    endfunction

    function automatic int color_lsb(input int poly, input int color_w);
        return poly * color_w;
    endfunction

    function automatic int depth_lsb(input int poly, input int depth_w);
        return poly * depth_w;
    endfunction

endpackage

// File: rtl/emern_edge_eval.sv
// emern_edge_eval
// Evaluates the three edge functions of one triangle and flags whether the
// pixel lies inside (either winding, boundary included, degenerate never).
// Ports:
//   clk       : clock
//   dpx_p1    : px - ax for edges v0->v1, v1->v2, v2->v0 (signed, packed LSB first)
//   dpy_p1    : py - ay for the same edges
//   ex_p1     : bx - ax for the same edges
//   ey_p1     : by - ay for the same edges
//   inside_p3 : registered inside flag, two cycles after the difference inputs
module emern_edge_eval
    import emern_raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                         clk,
    input  logic [3*(COORD_W+1)-1:0]     dpx_p1,
    input  logic [3*(COORD_W+1)-1:0]     dpy_p1,
    input  logic [3*(COORD_W+1)-1:0]     ex_p1,
    input  logic [3*(COORD_W+1)-1:0]     ey_p1,
    output logic                         inside_p3
);

    localparam int DIFF_W = COORD_W + 1;
    localparam int PROD_W = 2 * DIFF_W;
    localparam int EDGE_W = edge_w(COORD_W);

    function automatic logic signed [PROD_W-1:0] sext_diff(input logic [DIFF_W-1:0] v);
        return {{(PROD_W-DIFF_W){v[DIFF_W-1]}}, v};
    endfunction

    function automatic logic signed [EDGE_W-1:0] sext_prod(input logic [PROD_W-1:0] v);
        return {{(EDGE_W-PROD_W){v[PROD_W-1]}}, v};
    endfunction

    logic signed [PROD_W-1:0] prod_a_p2 [3];
    logic signed [PROD_W-1:0] prod_b_p2 [3];
    logic signed [EDGE_W-1:0] edge_val  [3];
    logic        [2:0]        pos;
    logic        [2:0]        neg;

    // ---- S1 -> S2: edge products ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            prod_a_p2[i] <= sext_diff(dpx_p1[i*DIFF_W +: DIFF_W]) * sext_diff(ey_p1[i*DIFF_W +: DIFF_W]);
            prod_b_p2[i] <= sext_diff(dpy_p1[i*DIFF_W +: DIFF_W]) * sext_diff(ex_p1[i*DIFF_W +: DIFF_W]);
        end
    end

    always_comb begin
        pos = '0;
        neg = '0;
        for (int i = 0; i < 3; i++) begin
            edge_val[i] = sext_prod(prod_a_p2[i]) - sext_prod(prod_b_p2[i]);
            neg[i]      = edge_val[i][EDGE_W-1];
            pos[i]      = !edge_val[i][EDGE_W-1] && (edge_val[i] != '0);
        end
    end

    // ---- S2 -> S3: inside flag ----
    // Inside when no two edges disagree in sign and at least one edge is non-zero.
    always_ff @(posedge clk) begin
        inside_p3 <= ((|pos) || (|neg)) && !((|pos) && (|neg));
    end

endmodule

// File: rtl/emern_raster_pipe.sv
// emern_raster_pipe
// Pipelined triangle rasterizer: evaluates NUM_POLY triangles per pixel,
// resolves depth and emits one colour per pixel with a fixed 4-cycle latency.
// Polygon configuration is double-buffered (shadow written by cfg_wr, copied
// to the active set on frame_start when pending).
// Optional build macro: EMERN_RASTER_STATS_EN adds output hit_count, the
// number of hit pixels in the previous frame (saturating at 0xFFFFF).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   pix_valid_in, pixel_x/y       : input pixel stream
//   frame_start                   : frame boundary pulse (config swap point)
//   cfg_wr + cfg_*                : shadow configuration write
//   pix_valid_out, pixel_color    : output pixel stream
//   hit_poly                      : one-hot winning polygon, 0 for background
//   cfg_pending                   : shadow written, not yet active
//   hit_count (stats build only)  : hit pixels counted over the last frame
module emern_raster_pipe
    import emern_raster_pkg::*;
#(
    parameter int NUM_POLY = NUM_POLY_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int DEPTH_W  = DEPTH_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid_in,
    input  logic [COORD_W-1:0]            pixel_x,
    input  logic [COORD_W-1:0]            pixel_y,
    input  logic                          frame_start,
    input  logic                          cfg_wr,
    input  logic [NUM_POLY-1:0]           cfg_poly_en,
    input  logic [COLOR_W-1:0]            cfg_bg_color,
    input  logic [NUM_POLY*COLOR_W-1:0]   cfg_color,
    input  logic [NUM_POLY*3*COORD_W-1:0] cfg_vx,
    input  logic [NUM_POLY*3*COORD_W-1:0] cfg_vy,
    input  logic [NUM_POLY*DEPTH_W-1:0]   cfg_depth,
    output logic                          pix_valid_out,
    output logic [COLOR_W-1:0]            pixel_color,
    output logic [NUM_POLY-1:0]           hit_poly,
    output logic                          cfg_pending
`ifdef EMERN_RASTER_STATS_EN
    ,
    output logic [19:0]                   hit_count
`endif
);

    localparam int DIFF_W = COORD_W + 1;
    localparam int VTX_W  = NUM_POLY * 3 * COORD_W;
    localparam int COL_W  = NUM_POLY * COLOR_W;
    localparam int DEP_W  = NUM_POLY * DEPTH_W;

    logic [NUM_POLY-1:0] sh_en,    act_en,    cur_en;
    logic [COLOR_W-1:0]  sh_bg,    act_bg,    cur_bg;
    logic [COL_W-1:0]    sh_color, act_color, cur_color;
    logic [VTX_W-1:0]    sh_vx,    act_vx,    cur_vx;
    logic [VTX_W-1:0]    sh_vy,    act_vy,    cur_vy;
    logic [DEP_W-1:0]    sh_depth, act_depth, cur_depth;
    logic                load_now;

    // A pixel sampled together with a swapping frame_start already sees the
    // incoming set, so the S1 snapshot bypasses the active registers.
    assign load_now  = frame_start && cfg_pending;
    assign cur_en    = load_now ? sh_en    : act_en;
    assign cur_bg    = load_now ? sh_bg    : act_bg;
    assign cur_color = load_now ? sh_color : act_color;
    assign cur_vx    = load_now ? sh_vx    : act_vx;
    assign cur_vy    = load_now ? sh_vy    : act_vy;
    assign cur_depth = load_now ? sh_depth : act_depth;

    // A simultaneous cfg_wr lands in the shadow after the swap read the old
    // shadow, and keeps cfg_pending set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en <= '0; sh_bg <= '0; sh_color <= '0; sh_vx <= '0; sh_vy <= '0; sh_depth <= '0;
            act_en <= '0; act_bg <= '0; act_color <= '0; act_vx <= '0; act_vy <= '0; act_depth <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (load_now) begin
                act_en    <= sh_en;
                act_bg    <= sh_bg;
                act_color <= sh_color;
                act_vx    <= sh_vx;
                act_vy    <= sh_vy;
                act_depth <= sh_depth;
                cfg_pending <= 1'b0;
            end
            if (cfg_wr) begin
                sh_en    <= cfg_poly_en;
                sh_bg    <= cfg_bg_color;
                sh_color <= cfg_color;
                sh_vx    <= cfg_vx;
                sh_vy    <= cfg_vy;
                sh_depth <= cfg_depth;
                cfg_pending <= 1'b1;
            end
        end
    end

    logic                vld_p1, vld_p2, vld_p3;
    logic [NUM_POLY-1:0] en_p1, en_p2, en_p3;
    logic [COLOR_W-1:0]  bg_p1, bg_p2, bg_p3;
    logic [COL_W-1:0]    color_p1, color_p2, color_p3;
    logic [DEP_W-1:0]    depth_p1, depth_p2, depth_p3;
    logic [NUM_POLY-1:0] inside_p3;

    // ---- input -> S1: coordinate differences and config snapshot ----
    for (genvar p = 0; p < NUM_POLY; p++) begin : g_poly
        logic [3*DIFF_W-1:0] dpx_p1, dpy_p1, ex_p1, ey_p1;

        always_ff @(posedge clk) begin
            for (int i = 0; i < 3; i++) begin
                dpx_p1[i*DIFF_W +: DIFF_W] <= {1'b0, pixel_x} - {1'b0, cur_vx[vtx_lsb(p, i, COORD_W) +: COORD_W]};
                dpy_p1[i*DIFF_W +: DIFF_W] <= {1'b0, pixel_y} - {1'b0, cur_vy[vtx_lsb(p, i, COORD_W) +: COORD_W]};
                ex_p1[i*DIFF_W +: DIFF_W]  <= {1'b0, cur_vx[vtx_lsb(p, (i + 1) % 3, COORD_W) +: COORD_W]}
                                            - {1'b0, cur_vx[vtx_lsb(p, i, COORD_W) +: COORD_W]};
                ey_p1[i*DIFF_W +: DIFF_W]  <= {1'b0, cur_vy[vtx_lsb(p, (i + 1) % 3, COORD_W) +: COORD_W]}
                                            - {1'b0, cur_vy[vtx_lsb(p, i, COORD_W) +: COORD_W]};
            end
        end

        emern_edge_eval #(.COORD_W(COORD_W)) u_edge (
            .clk       (clk),
            .dpx_p1    (dpx_p1),
            .dpy_p1    (dpy_p1),
            .ex_p1     (ex_p1),
            .ey_p1     (ey_p1),
            .inside_p3 (inside_p3[p])
        );
    end

    // Per-pixel config travels with the pixel so in-flight pixels are unaffected by swaps.
    always_ff @(posedge clk) begin
        en_p1 <= cur_en;  bg_p1 <= cur_bg;  color_p1 <= cur_color;  depth_p1 <= cur_depth;
        // ---- S1 -> S2 ----
        en_p2 <= en_p1;   bg_p2 <= bg_p1;   color_p2 <= color_p1;   depth_p2 <= depth_p1;
        // ---- S2 -> S3 ----
        en_p3 <= en_p2;   bg_p3 <= bg_p2;   color_p3 <= color_p2;   depth_p3 <= depth_p2;
    end

    logic                win_found;
    logic [DEPTH_W-1:0]  win_depth;
    logic [NUM_POLY-1:0] win_hot;
    logic [COLOR_W-1:0]  win_color;

    // Strict less-than keeps the lowest index on a depth tie.
    always_comb begin
        win_found = 1'b0;
        win_depth = '0;
        win_hot   = '0;
        win_color = bg_p3;
        for (int p = 0; p < NUM_POLY; p++) begin
            if (en_p3[p] && inside_p3[p] &&
                (!win_found || (depth_p3[depth_lsb(p, DEPTH_W) +: DEPTH_W] < win_depth))) begin
                win_found  = 1'b1;
                win_depth  = depth_p3[depth_lsb(p, DEPTH_W) +: DEPTH_W];
                win_hot    = '0;
                win_hot[p] = 1'b1;
                win_color  = color_p3[color_lsb(p, COLOR_W) +: COLOR_W];
            end
        end
    end

    // ---- S3 -> S4: depth resolve and output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            vld_p3        <= 1'b0;
            pix_valid_out <= 1'b0;
            pixel_color   <= '0;
            hit_poly      <= '0;
        end else begin
            vld_p1        <= pix_valid_in;
            vld_p2        <= vld_p1;
            vld_p3        <= vld_p2;
            pix_valid_out <= vld_p3;
            if (vld_p3) begin
                pixel_color <= win_color;
                hit_poly    <= win_hot;
            end
        end
    end

`ifdef EMERN_RASTER_STATS_EN
    logic [19:0] hit_cnt;
    logic        count_now;

    assign count_now = pix_valid_out && (hit_poly != '0);

    // A hit pixel coinciding with frame_start belongs to the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt   <= '0;
            hit_count <= '0;
        end else if (frame_start) begin
            hit_count <= hit_cnt;
            hit_cnt   <= {19'd0, count_now};
        end else if (count_now && (hit_cnt != 20'hFFFFF)) begin
            hit_cnt <= hit_cnt + 20'd1;
        end
    end
`endif

endmodule

// File: tb/tb_emern_raster_pipe.sv
module tb_emern_raster_pipe;

    localparam int NP   = 2;
    localparam int CW   = 10;
    localparam int COLW = 6;
    localparam int DW   = 3;
    localparam int NRND = 300;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pix_valid_in;
    logic [CW-1:0]        pixel_x, pixel_y;
    logic                 frame_start, cfg_wr;
    logic [NP-1:0]        cfg_poly_en;
    logic [COLW-1:0]      cfg_bg_color;
    logic [NP*COLW-1:0]   cfg_color;
    logic [NP*3*CW-1:0]   cfg_vx, cfg_vy;
    logic [NP*DW-1:0]     cfg_depth;
    logic                 pix_valid_out;
    logic [COLW-1:0]      pixel_color;
    logic [NP-1:0]        hit_poly;
    logic                 cfg_pending;
`ifdef EMERN_RASTER_STATS_EN
    logic [19:0]          hit_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: shadow / active sets and the pending flag.
    logic [NP-1:0]      m_sh_en,  m_act_en;
    logic [COLW-1:0]    m_sh_bg,  m_act_bg;
    logic [NP*COLW-1:0] m_sh_col, m_act_col;
    logic [NP*3*CW-1:0] m_sh_vx,  m_act_vx, m_sh_vy, m_act_vy;
    logic [NP*DW-1:0]   m_sh_dep, m_act_dep;
    logic               m_pend;

    logic               ev [NRND];
    logic [COLW-1:0]    ec [NRND];
    logic [NP-1:0]      eh [NRND];

    always #5 clk = ~clk;

    emern_raster_pipe #(.NUM_POLY(NP), .COORD_W(CW), .COLOR_W(COLW), .DEPTH_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid_in  (pix_valid_in),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .frame_start   (frame_start),
        .cfg_wr        (cfg_wr),
        .cfg_poly_en   (cfg_poly_en),
        .cfg_bg_color  (cfg_bg_color),
        .cfg_color     (cfg_color),
        .cfg_vx        (cfg_vx),
        .cfg_vy        (cfg_vy),
        .cfg_depth     (cfg_depth),
        .pix_valid_out (pix_valid_out),
        .pixel_color   (pixel_color),
        .hit_poly      (hit_poly),
        .cfg_pending   (cfg_pending)
`ifdef EMERN_RASTER_STATS_EN
        ,
        .hit_count     (hit_count)
`endif
    );

    task automatic model_reset();
        m_sh_en = '0; m_sh_bg = '0; m_sh_col = '0; m_sh_vx = '0; m_sh_vy = '0; m_sh_dep = '0;
        m_act_en = '0; m_act_bg = '0; m_act_col = '0; m_act_vx = '0; m_act_vy = '0; m_act_dep = '0;
        m_pend = 1'b0;
    endtask

    // Advance one clock; the model follows the buffering rules at the edge.
    task automatic tick();
        @(posedge clk);
        if (frame_start && m_pend) begin
            m_act_en = m_sh_en; m_act_bg = m_sh_bg; m_act_col = m_sh_col;
            m_act_vx = m_sh_vx; m_act_vy = m_sh_vy; m_act_dep = m_sh_dep;
            m_pend = 1'b0;
        end
        if (cfg_wr) begin
            m_sh_en = cfg_poly_en; m_sh_bg = cfg_bg_color; m_sh_col = cfg_color;
            m_sh_vx = cfg_vx; m_sh_vy = cfg_vy; m_sh_dep = cfg_depth;
            m_pend = 1'b1;
        end
        #1;
    endtask

    // Expected colour / winner for a pixel given the configuration it sees.
    function automatic void model_eval(input int px, input int py, input bit use_sh,
                                       output logic [COLW-1:0] c, output logic [NP-1:0] h);
        logic [NP-1:0]      en;
        logic [COLW-1:0]    bg;
        logic [NP*COLW-1:0] col;
        logic [NP*3*CW-1:0] vx, vy;
        logic [NP*DW-1:0]   dep;
        int      x[3], y[3];
        longint  e[3];
        int      best, best_d, d;
        bit      ins;
        en  = use_sh ? m_sh_en  : m_act_en;
        bg  = use_sh ? m_sh_bg  : m_act_bg;
        col = use_sh ? m_sh_col : m_act_col;
        vx  = use_sh ? m_sh_vx  : m_act_vx;
        vy  = use_sh ? m_sh_vy  : m_act_vy;
        dep = use_sh ? m_sh_dep : m_act_dep;
        best = -1;
        best_d = 0;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < 3; v++) begin
                x[v] = int'(vx[(p*3+v)*CW +: CW]);
                y[v] = int'(vy[(p*3+v)*CW +: CW]);
            end
            for (int k = 0; k < 3; k++) begin
                e[k] = longint'(px - x[k]) * longint'(y[(k+1)%3] - y[k])
                     - longint'(py - y[k]) * longint'(x[(k+1)%3] - x[k]);
            end
            ins = ((e[0] >= 0 && e[1] >= 0 && e[2] >= 0) || (e[0] <= 0 && e[1] <= 0 && e[2] <= 0))
                  && !(e[0] == 0 && e[1] == 0 && e[2] == 0);
            d = int'(dep[p*DW +: DW]);
            if (en[p] && ins && (best < 0 || d < best_d)) begin
                best = p;
                best_d = d;
            end
        end
        h = '0;
        if (best < 0) begin
            c = bg;
        end else begin
            c = col[best*COLW +: COLW];
            h[best] = 1'b1;
        end
    endfunction

    function automatic logic [CW-1:0] rand_coord();
        if ($urandom_range(0, 3) == 0) return CW'($urandom_range(0, 1023));
        return CW'($urandom_range(0, 63));
    endfunction

    task automatic set_tri(input int p, input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        cfg_vx[(p*3+0)*CW +: CW] = CW'(x0); cfg_vy[(p*3+0)*CW +: CW] = CW'(y0);
        cfg_vx[(p*3+1)*CW +: CW] = CW'(x1); cfg_vy[(p*3+1)*CW +: CW] = CW'(y1);
        cfg_vx[(p*3+2)*CW +: CW] = CW'(x2); cfg_vy[(p*3+2)*CW +: CW] = CW'(y2);
    endtask

    task automatic write_cfg();
        cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
    endtask

    task automatic apply_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    // Sends one isolated pixel; returns valid after 3 and 4 edges plus the output.
    task automatic run_pixel(input int px, input int py, output logic v3, output logic v4,
                             output logic [COLW-1:0] c, output logic [NP-1:0] h);
        pix_valid_in = 1'b1; pixel_x = CW'(px); pixel_y = CW'(py);
        tick();
        pix_valid_in = 1'b0;
        tick(); tick();
        v3 = pix_valid_out;
        tick();
        v4 = pix_valid_out; c = pixel_color; h = hit_poly;
    endtask

    task automatic basic_cfg(input logic [COLW-1:0] col0);
        cfg_poly_en = 2'b01; cfg_bg_color = 6'h03; cfg_depth = '0;
        cfg_color = '0; cfg_color[5:0] = col0;
        cfg_vx = '0; cfg_vy = '0;
        set_tri(0, 100, 100, 200, 100, 100, 200);
    endtask

    task automatic test_reset();
        logic v3, v4; logic [COLW-1:0] c; logic [NP-1:0] h;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pix_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", pix_valid_out); end
        n_cmp++; if (pixel_color !== 6'h00) begin n_bad++; $display("FAIL reset_color: got %h want 00", pixel_color); end
        n_cmp++; if (hit_poly !== 2'b00) begin n_bad++; $display("FAIL reset_hit: got %b want 00", hit_poly); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", cfg_pending); end
        rst = 1'b0;
        model_reset();
        run_pixel(150, 150, v3, v4, c, h);
        n_cmp++; if (v3 !== 1'b0 || v4 !== 1'b1) begin n_bad++; $display("FAIL reset_latency: got v3=%b v4=%b want 0 1", v3, v4); end
        n_cmp++; if (c !== 6'h00 || h !== 2'b00) begin n_bad++; $display("FAIL reset_bg: got %h/%b want 00/00", c, h); end
    endtask

    task automatic test_basic();
        logic v3, v4; logic [COLW-1:0] c; logic [NP-1:0] h;
        basic_cfg(6'h30);
        write_cfg();
        n_cmp++; if (cfg_pending !== 1'b1) begin n_bad++; $display("FAIL basic_pending_set: got %b want 1", cfg_pending); end
        apply_frame();
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL basic_pending_clr: got %b want 0", cfg_pending); end
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (v3 !== 1'b0 || v4 !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got v3=%b v4=%b want 0 1", v3, v4); end
        n_cmp++; if (c !== 6'h30 || h !== 2'b01) begin n_bad++; $display("FAIL basic_inside: got %h/%b want 30/01", c, h); end
        run_pixel(300, 300, v3, v4, c, h);
        n_cmp++; if (c !== 6'h03 || h !== 2'b00) begin n_bad++; $display("FAIL basic_outside: got %h/%b want 03/00", c, h); end
        run_pixel(150, 150, v3, v4, c, h);
        n_cmp++; if (c !== 6'h30 || h !== 2'b01) begin n_bad++; $display("FAIL basic_edge: got %h/%b want 30/01", c, h); end
    endtask

    task automatic test_depth();
        logic v3, v4; logic [COLW-1:0] c; logic [NP-1:0] h;
        basic_cfg(6'h30);
        cfg_poly_en = 2'b11;
        cfg_color[11:6] = 6'h0C;
        set_tri(1, 110, 110, 300, 110, 110, 300);
        cfg_depth[2:0] = 3'd5; cfg_depth[5:3] = 3'd2;
        write_cfg(); apply_frame();
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h0C || h !== 2'b10) begin n_bad++; $display("FAIL depth_nearer: got %h/%b want 0c/10", c, h); end
        cfg_depth[2:0] = 3'd3; cfg_depth[5:3] = 3'd3;
        write_cfg(); apply_frame();
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h30 || h !== 2'b01) begin n_bad++; $display("FAIL depth_tie: got %h/%b want 30/01", c, h); end
    endtask

    task automatic test_degenerate();
        logic v3, v4; logic [COLW-1:0] c; logic [NP-1:0] h;
        basic_cfg(6'h30);
        set_tri(0, 0, 0, 50, 50, 100, 100);
        write_cfg(); apply_frame();
        run_pixel(25, 25, v3, v4, c, h);
        n_cmp++; if (c !== 6'h03 || h !== 2'b00) begin n_bad++; $display("FAIL degen_on_line: got %h/%b want 03/00", c, h); end
        run_pixel(25, 30, v3, v4, c, h);
        n_cmp++; if (c !== 6'h03 || h !== 2'b00) begin n_bad++; $display("FAIL degen_off_line: got %h/%b want 03/00", c, h); end
    endtask

    task automatic test_double_buffer();
        logic v3, v4; logic [COLW-1:0] c; logic [NP-1:0] h;
        basic_cfg(6'h30);
        write_cfg(); apply_frame();
        cfg_color[5:0] = 6'h15;
        write_cfg();
        n_cmp++; if (cfg_pending !== 1'b1) begin n_bad++; $display("FAIL dbuf_pending_mid: got %b want 1", cfg_pending); end
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h30) begin n_bad++; $display("FAIL dbuf_old_color: got %h want 30", c); end
        apply_frame();
        n_cmp++; if (cfg_pending !== 1'b0) begin n_bad++; $display("FAIL dbuf_pending_swap: got %b want 0", cfg_pending); end
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h15) begin n_bad++; $display("FAIL dbuf_new_color: got %h want 15", c); end
        cfg_color[5:0] = 6'h2A;
        write_cfg();
        // Write, swap and a pixel all in the same cycle.
        cfg_color[5:0] = 6'h07;
        cfg_wr = 1'b1; frame_start = 1'b1;
        pix_valid_in = 1'b1; pixel_x = 10'd120; pixel_y = 10'd120;
        tick();
        cfg_wr = 1'b0; frame_start = 1'b0; pix_valid_in = 1'b0;
        n_cmp++; if (cfg_pending !== 1'b1) begin n_bad++; $display("FAIL dbuf_pending_simul: got %b want 1", cfg_pending); end
        tick(); tick(); tick();
        n_cmp++; if (pix_valid_out !== 1'b1 || pixel_color !== 6'h2A) begin
            n_bad++; $display("FAIL dbuf_swap_cycle_pixel: got v=%b %h want 1 2a", pix_valid_out, pixel_color);
        end
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h2A) begin n_bad++; $display("FAIL dbuf_pre_write_shadow: got %h want 2a", c); end
        apply_frame();
        run_pixel(120, 120, v3, v4, c, h);
        n_cmp++; if (c !== 6'h07) begin n_bad++; $display("FAIL dbuf_second_swap: got %h want 07", c); end
    endtask

    task automatic test_random_stream();
        logic [COLW-1:0] last_c;
        logic [NP-1:0]   last_h;
        bit              seen;
        int              k;
        seen = 0; last_c = '0; last_h = '0;
        for (int i = 0; i < NRND + 3; i++) begin
            if (i < NRND) begin
                pix_valid_in = (i == 0) || ($urandom_range(0, 9) < 8);
                pixel_x = rand_coord();
                pixel_y = rand_coord();
                cfg_wr = ($urandom_range(0, 9) == 0);
                if (cfg_wr) begin
                    for (int p = 0; p < NP; p++) begin
                        for (int v = 0; v < 3; v++) begin
                            cfg_vx[(p*3+v)*CW +: CW] = rand_coord();
                            cfg_vy[(p*3+v)*CW +: CW] = rand_coord();
                        end
                        cfg_color[p*COLW +: COLW] = COLW'($urandom);
                        cfg_depth[p*DW +: DW] = DW'($urandom_range(0, 3));
                    end
                    cfg_poly_en = NP'($urandom);
                    cfg_bg_color = COLW'($urandom);
                end
                frame_start = ($urandom_range(0, 9) == 0);
                ev[i] = pix_valid_in;
                model_eval(int'(pixel_x), int'(pixel_y), frame_start && m_pend, ec[i], eh[i]);
            end else begin
                pix_valid_in = 1'b0; cfg_wr = 1'b0; frame_start = 1'b0;
            end
            tick();
            if (i >= 3) begin
                k = i - 3;
                n_cmp++;
                if (pix_valid_out !== ev[k]) begin
                    n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, pix_valid_out, ev[k]);
                end
                if (ev[k]) begin
                    last_c = ec[k]; last_h = eh[k]; seen = 1;
                end
                if (seen) begin
                    n_cmp++;
                    if (pixel_color !== last_c || hit_poly !== last_h) begin
                        n_bad++; $display("FAIL rnd_pixel[%0d]: got %h/%b want %h/%b", k, pixel_color, hit_poly, last_c, last_h);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        basic_cfg(6'h30);
        write_cfg(); apply_frame();
        pix_valid_in = 1'b1; pixel_x = 10'd120; pixel_y = 10'd120;
        repeat (6) tick();
        n_cmp++; if (pix_valid_out !== 1'b1 || pixel_color !== 6'h30) begin
            n_bad++; $display("FAIL mid_prestream: got v=%b %h want 1 30", pix_valid_out, pixel_color);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (pix_valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %b want 0", pix_valid_out); end
        n_cmp++; if (pixel_color !== 6'h00 || hit_poly !== 2'b00) begin
            n_bad++; $display("FAIL mid_async_out: got %h/%b want 00/00", pixel_color, hit_poly);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                n_cmp++;
                if (pix_valid_out !== 1'b0 || pixel_color !== 6'h00) begin
                    n_bad++; $display("FAIL mid_drain[%0d]: got v=%b %h want 0 00", k, pix_valid_out, pixel_color);
                end
            end else begin
                n_cmp++;
                if (pix_valid_out !== 1'b1 || pixel_color !== 6'h00 || hit_poly !== 2'b00) begin
                    n_bad++; $display("FAIL mid_first_pixel: got v=%b %h/%b want 1 00/00", pix_valid_out, pixel_color, hit_poly);
                end
            end
        end
        pix_valid_in = 1'b0;
        repeat (4) tick();
    endtask

`ifdef EMERN_RASTER_STATS_EN
    task automatic test_stats();
        basic_cfg(6'h30);
        write_cfg(); apply_frame();
        repeat (6) tick();
        apply_frame();
        for (int i = 0; i < 15; i++) begin
            pix_valid_in = 1'b1;
            pixel_x = (i < 10) ? 10'd120 : 10'd300;
            pixel_y = pixel_x;
            tick();
        end
        pix_valid_in = 1'b0;
        repeat (6) tick();
        apply_frame();
        n_cmp++; if (hit_count !== 20'd10) begin n_bad++; $display("FAIL stats_count: got %0d want 10", hit_count); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pix_valid_in = 1'b0; pixel_x = '0; pixel_y = '0;
        frame_start = 1'b0; cfg_wr = 1'b0; cfg_poly_en = '0; cfg_bg_color = '0;
        cfg_color = '0; cfg_vx = '0; cfg_vy = '0; cfg_depth = '0;
        model_reset();
        test_reset();
        test_basic();
        test_depth();
        test_degenerate();
        test_double_buffer();
        test_random_stream();
        test_reset_midstream();
`ifdef EMERN_RASTER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
